// File: rtl/ll_window_mc.sv
// Multi-channel sliding-window line-length engine: per channel, sum of |x[n]-x[n-1]|
// over the last WIN_LEN differences, time-multiplexed input, 2-cycle result latency.
module ll_window_mc #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_CH     = 4,
    parameter  int WIN_LEN    = 64,
    parameter  int OUT_MEAN   = 0,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AD_W       = DATA_WIDTH + 1,
    localparam int LL_W       = AD_W + $clog2(WIN_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [CH_W-1:0]       in_ch,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  out_valid,
    output logic [CH_W-1:0]       out_ch,
    output logic [LL_W-1:0]       out_ll
);

    localparam int WP_W = $clog2(WIN_LEN);
    localparam int FW   = $clog2(WIN_LEN + 1);
    localparam logic [FW-1:0]   FULL_CNT = FW'(WIN_LEN);
    localparam logic [CH_W:0]   CH_LIMIT = (CH_W + 1)'(NUM_CH);

    logic [DATA_WIDTH-1:0] prev     [NUM_CH];
    logic                  primed   [NUM_CH];
    logic [FW-1:0]         fill     [NUM_CH];
    logic [WP_W-1:0]       wptr     [NUM_CH];
    logic [LL_W-1:0]       acc      [NUM_CH];
    logic [AD_W-1:0]       win_buf  [NUM_CH][WIN_LEN];

    logic                  s1_valid;
    logic [CH_W-1:0]       s1_ch;
    logic [AD_W-1:0]       s1_ad;
    logic                  s2_valid;
    logic [CH_W-1:0]       s2_ch;
    logic [LL_W-1:0]       s2_ll;

    logic                  accept;
    logic [AD_W-1:0]       diff;
    logic [AD_W-1:0]       abs_diff;
    logic [FW-1:0]         cur_fill;
    logic [AD_W-1:0]       oldest;
    logic                  win_full;
    logic [LL_W-1:0]       acc_nxt;
    logic [FW-1:0]         fill_nxt;

    // Stage 1 datapath: sign-extended difference against the channel's previous sample
    always_comb begin
        accept   = in_valid && !clear && ({1'b0, in_ch} < CH_LIMIT);
        diff     = {din[DATA_WIDTH-1], din} - {prev[in_ch][DATA_WIDTH-1], prev[in_ch]};
        abs_diff = diff[AD_W-1] ? (~diff + AD_W'(1)) : diff;
    end

    // Stage 2 datapath: running window sum, the oldest difference retires once full
    always_comb begin
        cur_fill = fill[s1_ch];
        oldest   = win_buf[s1_ch][wptr[s1_ch]];
        win_full = (cur_fill == FULL_CNT);
        acc_nxt  = acc[s1_ch] + LL_W'(s1_ad) - (win_full ? LL_W'(oldest) : '0);
        fill_nxt = win_full ? cur_fill : cur_fill + FW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_ad    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                prev[i]   <= '0;
                primed[i] <= 1'b0;
            end
        end else if (clear) begin
            s1_valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) primed[i] <= 1'b0;
        end else begin
            s1_valid <= accept && primed[in_ch];
            if (accept) begin
                prev[in_ch]   <= din;
                primed[in_ch] <= 1'b1;
                s1_ch         <= in_ch;
                s1_ad         <= abs_diff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_ch    <= '0;
            s2_ll    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                fill[i] <= '0;
                wptr[i] <= '0;
                acc[i]  <= '0;
            end
        end else if (clear) begin
            s2_valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                fill[i] <= '0;
                wptr[i] <= '0;
                acc[i]  <= '0;
            end
        end else begin
            s2_valid <= s1_valid && (fill_nxt == FULL_CNT);
            if (s1_valid) begin
                acc[s1_ch]  <= acc_nxt;
                fill[s1_ch] <= fill_nxt;
                wptr[s1_ch] <= wptr[s1_ch] + WP_W'(1);
                s2_ch       <= s1_ch;
                s2_ll       <= acc_nxt;
            end
        end
    end

    // Window storage carries no reset; fill==0 makes stale entries unreachable
    always_ff @(posedge clk) begin
        if (s1_valid && !clear) win_buf[s1_ch][wptr[s1_ch]] <= s1_ad;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_ll    <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_ch <= s2_ch;
                out_ll <= (OUT_MEAN != 0) ? (s2_ll >> WP_W) : s2_ll;
            end
        end
    end

endmodule

// File: tb/tb_ll_window_mc.sv
// Directed bench for ll_window_mc: three instances (sum, invalid-channel, mean) on shared stimulus.
module tb_ll_window_mc;

    typedef struct {
        int ch;
        int ll;
        int t;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        va, vb, vc;
    logic [1:0]  in_ch;
    logic [15:0] din;

    logic        a_valid, b_valid, c_valid;
    logic        a_ch, c_ch;
    logic [1:0]  b_ch;
    logic [18:0] a_ll, b_ll, c_ll;

    int   cyc = 0;
    int   t_last = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    rec_t qa[$];
    rec_t qb[$];
    rec_t qc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ll_window_mc #(.DATA_WIDTH(16), .NUM_CH(2), .WIN_LEN(4), .OUT_MEAN(0)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(va), .in_ch(in_ch[0]), .din(din),
        .out_valid(a_valid), .out_ch(a_ch), .out_ll(a_ll));

    ll_window_mc #(.DATA_WIDTH(16), .NUM_CH(3), .WIN_LEN(4), .OUT_MEAN(0)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(vb), .in_ch(in_ch), .din(din),
        .out_valid(b_valid), .out_ch(b_ch), .out_ll(b_ll));

    ll_window_mc #(.DATA_WIDTH(16), .NUM_CH(2), .WIN_LEN(4), .OUT_MEAN(1)) dut_c (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(vc), .in_ch(in_ch[0]), .din(din),
        .out_valid(c_valid), .out_ch(c_ch), .out_ll(c_ll));

    // Record every result strobe with the cycle it became visible
    always @(negedge clk) begin
        if (a_valid) qa.push_back('{int'(a_ch), int'(a_ll), cyc});
        if (b_valid) qb.push_back('{int'(b_ch), int'(b_ll), cyc});
        if (c_valid) qc.push_back('{int'(c_ch), int'(c_ll), cyc});
    end

    task automatic put(input logic [2:0] m, input logic [1:0] ch, input int v);
        @(negedge clk);
        va     = m[0];
        vb     = m[1];
        vc     = m[2];
        in_ch  = ch;
        din    = 16'(v);
        t_last = cyc + 1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        va = 1'b0;
        vb = 1'b0;
        vc = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        va    = 1'b1;
        vb    = 1'b1;
        vc    = 1'b1;
        in_ch = 2'd0;
        din   = 16'd1234;
        @(negedge clk);
        clear = 1'b0;
        va    = 1'b0;
        vb    = 1'b0;
        vc    = 1'b0;
        idle(2);
        qa.delete();
        qb.delete();
        qc.delete();
    endtask

    task automatic run_case1(input logic [2:0] m, output int t4, output int t5);
        put(m, 2'd0, 0);
        put(m, 2'd0, 1);
        put(m, 2'd0, 10);
        put(m, 2'd0, 4);
        put(m, 2'd0, 4);
        t4 = t_last;
        put(m, 2'd0, -6);
        t5 = t_last;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (a_valid !== 1'b0 || a_ch !== 1'b0 || a_ll !== 19'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got v=%0b ch=%0d ll=%0d, expected 0/0/0", a_valid, a_ch, a_ll);
        end
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        n_vec++;
        if (a_valid !== 1'b0 || a_ll !== 19'd0) begin
            n_bad++;
            $display("[TB] FAIL after_release: got v=%0b ll=%0d, expected 0/0", a_valid, a_ll);
        end
    endtask

    task automatic test_back_to_back();
        int t4, t5;
        int exp_ll[2];
        int exp_t[2];
        do_clear();
        run_case1(3'b001, t4, t5);
        idle(5);
        exp_ll = '{16, 25};
        exp_t  = '{t4 + 2, t5 + 2};
        n_vec++;
        if (qa.size() != 2) begin
            n_bad++;
            $display("[TB] FAIL b2b_count: got %0d outputs, expected 2", qa.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (i >= qa.size()) begin
                n_bad++;
                $display("[TB] FAIL b2b_out%0d: missing, expected ll=%0d", i, exp_ll[i]);
            end else if (qa[i].ch != 0 || qa[i].ll != exp_ll[i] || qa[i].t != exp_t[i]) begin
                n_bad++;
                $display("[TB] FAIL b2b_out%0d: got ch=%0d ll=%0d t=%0d, expected ch=0 ll=%0d t=%0d",
                         i, qa[i].ch, qa[i].ll, qa[i].t, exp_ll[i], exp_t[i]);
            end
        end
        n_vec++;
        if (a_valid !== 1'b0 || a_ll !== 19'd25) begin
            n_bad++;
            $display("[TB] FAIL hold: got v=%0b ll=%0d, expected 0/25", a_valid, a_ll);
        end
    endtask

    task automatic test_interleave();
        int t0, t1;
        int exp_ch[2];
        int exp_ll[2];
        int exp_t[2];
        int s0[5];
        int s1[5];
        do_clear();
        s0 = '{0, 1, 10, 4, 4};
        s1 = '{100, 90, 90, 95, 75};
        for (int i = 0; i < 5; i++) begin
            put(3'b001, 2'd0, s0[i]);
            t0 = t_last;
            put(3'b001, 2'd1, s1[i]);
            t1 = t_last;
        end
        idle(5);
        exp_ch = '{0, 1};
        exp_ll = '{16, 35};
        exp_t  = '{t0 + 2, t1 + 2};
        n_vec++;
        if (qa.size() != 2) begin
            n_bad++;
            $display("[TB] FAIL ilv_count: got %0d outputs, expected 2", qa.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (i >= qa.size()) begin
                n_bad++;
                $display("[TB] FAIL ilv_out%0d: missing, expected ll=%0d", i, exp_ll[i]);
            end else if (qa[i].ch != exp_ch[i] || qa[i].ll != exp_ll[i] || qa[i].t != exp_t[i]) begin
                n_bad++;
                $display("[TB] FAIL ilv_out%0d: got ch=%0d ll=%0d t=%0d, expected ch=%0d ll=%0d t=%0d",
                         i, qa[i].ch, qa[i].ll, qa[i].t, exp_ch[i], exp_ll[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_extremes();
        do_clear();
        for (int i = 0; i < 5; i++) put(3'b001, 2'd1, (i % 2 == 0) ? -32768 : 32767);
        idle(5);
        n_vec++;
        if (qa.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL ext_count: got %0d outputs, expected 1", qa.size());
        end else if (qa[0].ch != 1 || qa[0].ll != 262140) begin
            n_bad++;
            $display("[TB] FAIL ext_ll: got ch=%0d ll=%0d, expected ch=1 ll=262140", qa[0].ch, qa[0].ll);
        end
    endtask

    task automatic test_clear();
        int t4, t5;
        do_clear();
        run_case1(3'b001, t4, t5);
        idle(5);
        n_vec++;
        if (qa.size() != 2) begin
            n_bad++;
            $display("[TB] FAIL clr_pre_count: got %0d outputs, expected 2", qa.size());
        end
        do_clear();
        for (int i = 0; i < 4; i++) put(3'b001, 2'd0, 5);
        idle(5);
        n_vec++;
        if (qa.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL clr_no_out: got %0d outputs, expected 0", qa.size());
        end
        put(3'b001, 2'd0, 6);
        idle(5);
        n_vec++;
        if (qa.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL clr_count: got %0d outputs, expected 1", qa.size());
        end else if (qa[0].ll != 1) begin
            n_bad++;
            $display("[TB] FAIL clr_ll: got %0d, expected 1", qa[0].ll);
        end
    endtask

    task automatic test_reset_mid();
        int s[5];
        do_clear();
        put(3'b001, 2'd0, 0);
        put(3'b001, 2'd0, 1);
        put(3'b001, 2'd0, 10);
        put(3'b001, 2'd0, 4);
        @(negedge clk);
        va  = 1'b0;
        rst = 1'b0;
        #1;
        n_vec++;
        if (a_valid !== 1'b0 || a_ll !== 19'd0) begin
            n_bad++;
            $display("[TB] FAIL mid_rst: got v=%0b ll=%0d, expected 0/0", a_valid, a_ll);
        end
        @(negedge clk);
        rst = 1'b1;
        s = '{4, -6, 0, 1, 10};
        for (int i = 0; i < 4; i++) put(3'b001, 2'd0, s[i]);
        idle(5);
        n_vec++;
        if (qa.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL mid_early: got %0d outputs, expected 0", qa.size());
        end
        put(3'b001, 2'd0, s[4]);
        idle(5);
        n_vec++;
        if (qa.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL mid_count: got %0d outputs, expected 1", qa.size());
        end else if (qa[0].ll != 26) begin
            n_bad++;
            $display("[TB] FAIL mid_ll: got %0d, expected 26", qa[0].ll);
        end
    endtask

    task automatic test_bad_channel();
        int t4, t5;
        int exp_ll[2];
        int exp_t[2];
        do_clear();
        put(3'b010, 2'd0, 0);
        put(3'b010, 2'd3, 500);
        put(3'b010, 2'd0, 1);
        put(3'b010, 2'd3, -700);
        put(3'b010, 2'd0, 10);
        put(3'b010, 2'd0, 4);
        put(3'b010, 2'd3, 9);
        put(3'b010, 2'd0, 4);
        t4 = t_last;
        put(3'b010, 2'd0, -6);
        t5 = t_last;
        put(3'b010, 2'd3, 30000);
        idle(5);
        exp_ll = '{16, 25};
        exp_t  = '{t4 + 2, t5 + 2};
        n_vec++;
        if (qb.size() != 2) begin
            n_bad++;
            $display("[TB] FAIL badch_count: got %0d outputs, expected 2", qb.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (i >= qb.size()) begin
                n_bad++;
                $display("[TB] FAIL badch_out%0d: missing, expected ll=%0d", i, exp_ll[i]);
            end else if (qb[i].ch != 0 || qb[i].ll != exp_ll[i] || qb[i].t != exp_t[i]) begin
                n_bad++;
                $display("[TB] FAIL badch_out%0d: got ch=%0d ll=%0d t=%0d, expected ch=0 ll=%0d t=%0d",
                         i, qb[i].ch, qb[i].ll, qb[i].t, exp_ll[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_mean();
        int t4, t5;
        int exp_ll[2];
        do_clear();
        run_case1(3'b100, t4, t5);
        idle(5);
        exp_ll = '{4, 6};
        n_vec++;
        if (qc.size() != 2) begin
            n_bad++;
            $display("[TB] FAIL mean_count: got %0d outputs, expected 2", qc.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (i >= qc.size()) begin
                n_bad++;
                $display("[TB] FAIL mean_out%0d: missing, expected ll=%0d", i, exp_ll[i]);
            end else if (qc[i].ll != exp_ll[i] || qc[i].t != ((i == 0) ? t4 : t5) + 2) begin
                n_bad++;
                $display("[TB] FAIL mean_out%0d: got ll=%0d t=%0d, expected ll=%0d",
                         i, qc[i].ll, qc[i].t, exp_ll[i]);
            end
        end
    endtask

    initial begin
        rst   = 1'b0;
        clear = 1'b0;
        va    = 1'b0;
        vb    = 1'b0;
        vc    = 1'b0;
        in_ch = 2'd0;
        din   = 16'd0;
        test_reset();
        test_back_to_back();
        test_interleave();
        test_extremes();
        test_clear();
        test_reset_mid();
        test_bad_channel();
        test_mean();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
